knn_sequencer: RTL and testbench
================================

Name: knn_sequencer

Overview:
- Host-facing controller that sequences one k-nearest-neighbour query through the KNN core datapath.
- Core interface: start, dimension-serial data stream, done, k, read strobe, result name/value.
- The block accepts a host word stream (query point, then training points) and paces it into the core.
- It then signals end-of-data, waits a fixed settle latency, and reads k results back out over a valid/ready result port.
- Sits between the AXI register/stream shell and the core.

Parameters:
- dataWidth, 32, width of one dimension value.
- numberOfDimensions, 5, words per point (query and training).
- pointCountWidth, 16, width of the training-point count.
- resultLatency, 4, cycles between core_done and first core_rd (≥1).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_start  in  1  one-cycle request to begin a query; sampled only in IDLE.
- cmd_abort  in  1  abort current query; any state returns to IDLE.
- cfg_k  in  32  neighbours requested; latched on accepted cmd_start.
- cfg_num_points  in  pointCountWidth  training points; latched on accepted cmd_start.
- s_valid  in  1  host data word valid.
- s_data  in  dataWidth  host data word.
- s_ready  out  1  sequencer accepts word (transfer = s_valid & s_ready).
- core_start  out  1  one-cycle pulse opening a query in the core.
- core_load  out  1  core_dataValueIn valid this cycle.
- core_dataValueIn  out  dataWidth  registered copy of the accepted word.
- core_k  out  32  latched k, held stable for the whole query.
- core_done  out  1  one-cycle end-of-data pulse.
- core_rd  out  1  one-cycle read strobe, one per result.
- core_dataNameOut  in  32  result name, valid 1 cycle after core_rd.
- core_dataValueOut  in  dataWidth  result distance, valid 1 cycle after core_rd.
- r_valid  out  1  result available.
- r_ready  in  1  host accepts result.
- r_name  out  32  captured name.
- r_value  out  dataWidth  captured distance.
- busy  out  1  state != IDLE.
- done_pulse  out  1  one-cycle pulse when last result is accepted.
- err_pulse  out  1  one-cycle pulse when cmd_start is rejected.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. The async assert takes effect immediately regardless of state.
- IDLE:
  - Valid cmd_start (cfg_num_points≠0, cfg_k≠0, cfg_k≤cfg_num_points): latch cfg_k/cfg_num_points, go to START.
  - Invalid cmd_start: err_pulse next cycle, stay in IDLE.
- START: core_start=1 for exactly one cycle, then go to QUERY.
- QUERY: s_ready=1.
  - Each transfer: next cycle core_load=1 and core_dataValueIn=s_data.
  - No transfer: core_load=0; core_dataValueIn holds.
  - dim_cnt counts 0..numberOfDimensions-1; on wrap go to POINTS.
- POINTS: same transfer rule. dim_cnt wraps per point, pt_cnt increments on each wrap.
  - On transfer of the last dim of point cfg_num_points-1: s_ready drops the next cycle, go to FLUSH.
  - Total accepted words = numberOfDimensions×(cfg_num_points+1).
- FLUSH: core_done=1 for one cycle, coincident with the final core_load. Go to SETTLE.
- SETTLE: count resultLatency cycles, then go to READ.
- READ:
  - core_rd=1 one cycle, then go to CAPTURE.
  - Next cycle, register core_dataNameOut/core_dataValueOut into r_name/r_value and set r_valid=1; go to HOLD.
- HOLD:
  - r_valid stays high, and r_name/r_value stay stable, until r_ready.
  - On handshake: r_valid=0. If res_cnt<k-1, increment and go to READ; else done_pulse=1 and go to IDLE.
  - Maximum result throughput: one result per 3 cycles.
- cmd_start outside IDLE: ignored, no err_pulse.
- cmd_abort: next cycle state=IDLE; s_ready/r_valid/core_* strobes=0; counters cleared; no core_done, done_pulse, or err_pulse.
  - cmd_abort in the same cycle as cmd_start in IDLE: abort wins, no start.
- s_valid with s_ready=0: no transfer; data is ignored, not buffered.
- busy=1 from the cycle after an accepted cmd_start through the cycle done_pulse is asserted.

Test Plan:
- Nominal, dims=5, N=3, k=2, s_valid held high:
  - 20 words accepted; 20 core_load pulses in order, the first with core_dataValueIn equal to the first word.
  - core_done in the same cycle as the 20th core_load.
  - First core_rd exactly 4+1 cycles after core_done.
  - Two results returned with r_ready=1; done_pulse once.
- Backpressure/bubbles: s_valid toggling 1,0,0,1…
  - core_load only on transfers; core_dataValueIn holds during gaps.
  - Result r_ready held low 10 cycles: r_valid, r_name, r_value stable; no extra core_rd.
- Config errors: cfg_k=0; cfg_num_points=0; cfg_k=4 with N=3.
  - Each gives err_pulse, busy stays 0, no core_start.
- cmd_abort mid-POINTS (word 12):
  - Next cycle busy=0, s_ready=0; core_done never pulses.
  - A following valid command runs normally.
- Async reset asserted in HOLD, between clock edges:
  - Outputs 0 immediately; IDLE after release.
- Boundary, N=1, k=1:
  - 10 words, one core_rd, one result, done_pulse.
  - cmd_start during busy is ignored.

Source files
------------

// File: rtl/knn_sequencer.sv
// knn_sequencer: paces one host k-NN query through the KNN core datapath,
// then reads the k nearest results back out over a valid/ready port.
module knn_sequencer #(
  parameter int dataWidth          = 32,
  parameter int numberOfDimensions = 5,
  parameter int pointCountWidth    = 16,
  parameter int resultLatency      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_start,
  input  logic                       cmd_abort,
  input  logic [31:0]                cfg_k,
  input  logic [pointCountWidth-1:0] cfg_num_points,
  input  logic                       s_valid,
  input  logic [dataWidth-1:0]       s_data,
  output logic                       s_ready,
  output logic                       core_start,
  output logic                       core_load,
  output logic [dataWidth-1:0]       core_dataValueIn,
  output logic [31:0]                core_k,
  output logic                       core_done,
  output logic                       core_rd,
  input  logic [31:0]                core_dataNameOut,
  input  logic [dataWidth-1:0]       core_dataValueOut,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [31:0]                r_name,
  output logic [dataWidth-1:0]       r_value,
  output logic                       busy,
  output logic                       done_pulse,
  output logic                       err_pulse
);

  localparam int dim_w    = $clog2(numberOfDimensions + 1);
  localparam int settle_w = $clog2(resultLatency + 1);

  typedef enum logic [3:0] {
    IDLE, START, QUERY, POINTS, FLUSH, SETTLE, READ, CAPTURE, HOLD
  } state_t;

  state_t state, next_state;

  logic [dim_w-1:0]           dim_cnt;
  logic [pointCountWidth-1:0] pt_cnt;
  logic [pointCountWidth-1:0] num_points;
  logic [settle_w-1:0]        settle_cnt;
  logic [31:0]                res_cnt;

  logic cfg_ok;
  logic accept_start;
  logic transfer;
  logic last_dim;
  logic last_point;
  logic last_result;
  logic settle_done;

  assign s_ready      = (state == QUERY) || (state == POINTS);
  assign transfer     = s_valid && s_ready && !cmd_abort;
  assign cfg_ok       = (cfg_num_points != '0) && (cfg_k != 32'd0) &&
                        (cfg_k <= 32'(cfg_num_points));
  assign accept_start = (state == IDLE) && cmd_start && !cmd_abort;
  assign last_dim     = (dim_cnt == dim_w'(numberOfDimensions - 1));
  assign last_point   = (pt_cnt == num_points - pointCountWidth'(1));
  assign last_result  = (res_cnt == core_k - 32'd1);
  assign settle_done  = (settle_cnt == settle_w'(resultLatency - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Abort overrides every transition; strobes are decoded straight from state.
  always_comb begin
    next_state = state;
    core_start = 1'b0;
    core_done  = 1'b0;
    core_rd    = 1'b0;
    r_valid    = 1'b0;
    busy       = (state != IDLE);
    done_pulse = 1'b0;
    if (cmd_abort) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (cmd_start && cfg_ok) next_state = START;
        START:   next_state = QUERY;
        QUERY:   if (transfer && last_dim) next_state = POINTS;
        POINTS:  if (transfer && last_dim && last_point) next_state = FLUSH;
        FLUSH:   next_state = SETTLE;
        SETTLE:  if (settle_done) next_state = READ;
        READ:    next_state = CAPTURE;
        CAPTURE: next_state = HOLD;
        HOLD:    if (r_ready) next_state = last_result ? IDLE : READ;
        default: next_state = IDLE;
      endcase
    end
    case (state)
      START:   core_start = 1'b1;
      FLUSH:   core_done  = 1'b1;
      READ:    core_rd    = 1'b1;
      HOLD: begin
        r_valid    = 1'b1;
        done_pulse = r_ready && last_result && !cmd_abort;
      end
      default: ;
    endcase
  end

  // Datapath registers and the dimension/point/settle/result counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dim_cnt          <= '0;
      pt_cnt           <= '0;
      num_points       <= '0;
      settle_cnt       <= '0;
      res_cnt          <= '0;
      core_k           <= '0;
      core_load        <= 1'b0;
      core_dataValueIn <= '0;
      r_name           <= '0;
      r_value          <= '0;
      err_pulse        <= 1'b0;
    end else if (cmd_abort) begin
      dim_cnt    <= '0;
      pt_cnt     <= '0;
      settle_cnt <= '0;
      res_cnt    <= '0;
      core_load  <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      core_load <= transfer;
      err_pulse <= (state == IDLE) && cmd_start && !cfg_ok;
      if (transfer) core_dataValueIn <= s_data;

      if (accept_start && cfg_ok) begin
        core_k     <= cfg_k;
        num_points <= cfg_num_points;
        dim_cnt    <= '0;
        pt_cnt     <= '0;
        res_cnt    <= '0;
      end else if (transfer) begin
        if (last_dim) begin
          dim_cnt <= '0;
          if (state == POINTS) pt_cnt <= pt_cnt + pointCountWidth'(1);
        end else begin
          dim_cnt <= dim_cnt + dim_w'(1);
        end
      end

      if (state == SETTLE && !settle_done) settle_cnt <= settle_cnt + settle_w'(1);
      else                                 settle_cnt <= '0;

      if (state == CAPTURE) begin
        r_name  <= core_dataNameOut;
        r_value <= core_dataValueOut;
      end

      if (state == HOLD && r_ready) begin
        if (last_result) begin
          res_cnt <= '0;
          pt_cnt  <= '0;
        end else begin
          res_cnt <= res_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_knn_sequencer.sv
// Directed bench for knn_sequencer with a small core model that answers each
// core_rd one cycle later with a predictable name/value pair.
module tb_knn_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_start, cmd_abort;
  logic [31:0] cfg_k;
  logic [15:0] cfg_num_points;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        core_start, core_load, core_done, core_rd;
  logic [31:0] core_dataValueIn, core_k;
  logic [31:0] core_dataNameOut, core_dataValueOut;
  logic        r_valid, r_ready;
  logic [31:0] r_name, r_value;
  logic        busy, done_pulse, err_pulse;

  knn_sequencer #(
    .dataWidth(32), .numberOfDimensions(5), .pointCountWidth(16), .resultLatency(4)
  ) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cfg_k(cfg_k), .cfg_num_points(cfg_num_points),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .core_start(core_start), .core_load(core_load), .core_dataValueIn(core_dataValueIn),
    .core_k(core_k), .core_done(core_done), .core_rd(core_rd),
    .core_dataNameOut(core_dataNameOut), .core_dataValueOut(core_dataValueOut),
    .r_valid(r_valid), .r_ready(r_ready), .r_name(r_name), .r_value(r_value),
    .busy(busy), .done_pulse(done_pulse), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: result i carries name A000+i and value 5000+16*i.
  int model_idx = 0;
  always @(posedge clk) begin
    if (core_rd) begin
      core_dataNameOut  <= 32'hA000 + 32'(model_idx);
      core_dataValueOut <= 32'h5000 + 32'(16 * model_idx);
      model_idx         <= model_idx + 1;
    end
  end

  // Event monitor, sampled on the falling edge.
  int load_cnt = 0, xfer_cnt = 0, done_cnt = 0, rd_cnt = 0, start_cnt = 0;
  int err_cnt = 0, donep_cnt = 0, busy_cnt = 0, hold_viol = 0, donep_busy = 0;
  int done_cyc = 0, rd_cyc = 0, loads_at_done = 0;
  bit done_with_load = 0, await_rd = 0;
  logic [31:0] prev_val = '0;
  logic [31:0] loaded[$];
  always @(negedge clk) begin
    if (core_load) begin
      load_cnt++;
      loaded.push_back(core_dataValueIn);
    end else if (core_dataValueIn !== prev_val) begin
      hold_viol++;
    end
    prev_val = core_dataValueIn;
    if (s_valid && s_ready) xfer_cnt++;
    if (core_done) begin
      done_cnt++;
      done_cyc = cyc;
      done_with_load = core_load;
      loads_at_done = load_cnt;
      await_rd = 1;
    end
    if (core_rd) begin
      if (await_rd) rd_cyc = cyc;
      await_rd = 0;
      rd_cnt++;
    end
    if (core_start) start_cnt++;
    if (err_pulse) err_cnt++;
    if (done_pulse) donep_cnt++;
    if (done_pulse && busy) donep_busy++;
    if (busy) busy_cnt++;
  end

  int b_load, b_xfer, b_done, b_rd, b_start, b_err, b_donep, b_busy, b_hold, b_donep_busy, b_qidx;
  int exp_idx = 0;

  task automatic snap();
    b_load = load_cnt; b_xfer = xfer_cnt; b_done = done_cnt; b_rd = rd_cnt;
    b_start = start_cnt; b_err = err_cnt; b_donep = donep_cnt; b_busy = busy_cnt;
    b_hold = hold_viol; b_donep_busy = donep_busy; b_qidx = loaded.size();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startQuery(input logic [31:0] k, input logic [15:0] n);
    cfg_k = k;
    cfg_num_points = n;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  // Streams count words base, base+1, ...; gappy drives valid on every third cycle.
  task automatic applyStimulus(input int count, input bit gappy, input logic [31:0] base);
    int sent = 0;
    int n = 0;
    bit xfer;
    while (sent < count && n < 400) begin
      s_valid = gappy ? (n % 3 == 0) : 1'b1;
      s_data  = base + 32'(sent);
      @(negedge clk);
      xfer = s_valid && s_ready;
      tick();
      if (xfer) sent++;
      n++;
    end
    s_valid = 1'b0;
    checkOutput("stim_words_sent", 64'(sent), 64'(count));
  endtask

  task automatic checkOrder(input string tag, input int count, input logic [31:0] base);
    int errs = 0;
    for (int i = 0; i < count; i++)
      if (b_qidx + i >= loaded.size() || loaded[b_qidx + i] !== base + 32'(i)) errs++;
    checkOutput(tag, 64'(errs), 64'd0);
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!r_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 64'(r_valid), 64'd1);
  endtask

  task automatic readResults(input int k, input int stall);
    logic [31:0] hn, hv;
    int rd0;
    bit stable;
    r_ready = (stall == 0);
    for (int j = 0; j < k; j++) begin
      waitValid("r_valid_wait");
      checkOutput("r_name", r_name, 64'(32'hA000 + 32'(exp_idx)));
      checkOutput("r_value", r_value, 64'(32'h5000 + 32'(16 * exp_idx)));
      exp_idx++;
      if (stall > 0 && j == 0) begin
        hn = r_name; hv = r_value; rd0 = rd_cnt; stable = 1;
        repeat (stall) begin
          @(negedge clk);
          if (!r_valid || r_name !== hn || r_value !== hv) stable = 0;
        end
        checkOutput("hold_stable", 64'(stable), 64'd1);
        checkOutput("hold_no_extra_rd", 64'(rd_cnt - rd0), 64'd0);
      end
      r_ready = 1'b1;
      tick();
      r_ready = (stall == 0);
    end
    r_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_start = 0; cmd_abort = 0; cfg_k = 0; cfg_num_points = 0;
    s_valid = 0; s_data = 0; r_ready = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_strobes",
      {55'd0, s_ready, core_start, core_load, core_done, core_rd, r_valid, busy, done_pulse, err_pulse}, 64'd0);
    checkOutput("reset_data", {core_dataValueIn, core_k}, 64'd0);
    checkOutput("reset_result", {r_name, r_value}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    tick();

    $display("[TB] nominal N=3 k=2");
    snap();
    startQuery(2, 3);
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    applyStimulus(20, 0, 32'h100);
    readResults(2, 0);
    checkOutput("nom_loads", 64'(load_cnt - b_load), 64'd20);
    checkOrder("nom_order", 20, 32'h100);
    checkOutput("nom_first_word", loaded[b_qidx], 64'h100);
    checkOutput("nom_done_count", 64'(done_cnt - b_done), 64'd1);
    checkOutput("nom_done_with_load", 64'(done_with_load), 64'd1);
    checkOutput("nom_loads_at_done", 64'(loads_at_done - b_load), 64'd20);
    checkOutput("nom_rd_latency", 64'(rd_cyc - done_cyc), 64'd5);
    checkOutput("nom_rd_count", 64'(rd_cnt - b_rd), 64'd2);
    checkOutput("nom_done_pulse", 64'(donep_cnt - b_donep), 64'd1);
    checkOutput("nom_done_pulse_busy", 64'(donep_busy - b_donep_busy), 64'd1);
    checkOutput("nom_core_start", 64'(start_cnt - b_start), 64'd1);
    checkOutput("nom_idle_after", 64'(busy), 64'd0);

    $display("[TB] bubbles and result backpressure");
    snap();
    startQuery(2, 3);
    applyStimulus(20, 1, 32'h200);
    readResults(2, 10);
    checkOutput("bub_loads", 64'(load_cnt - b_load), 64'd20);
    checkOutput("bub_loads_eq_xfers", 64'(load_cnt - b_load), 64'(xfer_cnt - b_xfer));
    checkOrder("bub_order", 20, 32'h200);
    checkOutput("bub_hold_gaps", 64'(hold_viol - b_hold), 64'd0);
    checkOutput("bub_rd_count", 64'(rd_cnt - b_rd), 64'd2);
    checkOutput("bub_done_pulse", 64'(donep_cnt - b_donep), 64'd1);

    $display("[TB] config errors");
    for (int c = 0; c < 3; c++) begin
      logic [31:0] kk;
      logic [15:0] nn;
      kk = (c == 0) ? 32'd0 : (c == 1) ? 32'd1 : 32'd4;
      nn = (c == 0) ? 16'd3 : (c == 1) ? 16'd0 : 16'd3;
      snap();
      startQuery(kk, nn);
      tick(); tick();
      checkOutput("cfg_err_pulse", 64'(err_cnt - b_err), 64'd1);
      checkOutput("cfg_no_busy", 64'(busy_cnt - b_busy), 64'd0);
      checkOutput("cfg_no_start", 64'(start_cnt - b_start), 64'd0);
    end

    $display("[TB] abort mid-points");
    snap();
    startQuery(2, 3);
    applyStimulus(12, 0, 32'h300);
    cmd_abort = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD;
    tick();
    cmd_abort = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_s_ready", 64'(s_ready), 64'd0);
    checkOutput("abort_no_load", 64'(core_load), 64'd0);
    repeat (20) tick();
    checkOutput("abort_no_done", 64'(done_cnt - b_done), 64'd0);
    checkOutput("abort_no_rd", 64'(rd_cnt - b_rd), 64'd0);
    snap();
    startQuery(1, 2);
    applyStimulus(15, 0, 32'h400);
    readResults(1, 0);
    checkOutput("post_abort_loads", 64'(load_cnt - b_load), 64'd15);
    checkOrder("post_abort_order", 15, 32'h400);
    checkOutput("post_abort_done", 64'(done_cnt - b_done), 64'd1);
    checkOutput("post_abort_done_pulse", 64'(donep_cnt - b_donep), 64'd1);

    $display("[TB] async reset in HOLD");
    startQuery(1, 1);
    applyStimulus(10, 0, 32'h500);
    r_ready = 1'b0;
    waitValid("rst_r_valid_wait");
    checkOutput("rst_r_name_before", r_name, 64'(32'hA000 + 32'(exp_idx)));
    exp_idx++;
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_imm_strobes", {61'd0, r_valid, busy, s_ready}, 64'd0);
    checkOutput("rst_imm_data", {r_name, core_k}, 64'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_idle_after", {62'd0, busy, r_valid}, 64'd0);

    $display("[TB] boundary N=1 k=1 with cmd_start while busy");
    snap();
    startQuery(1, 1);
    tick();
    cfg_k = 32'd0; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0; cfg_k = 32'd1;
    checkOutput("bnd_core_k", core_k, 64'd1);
    applyStimulus(10, 0, 32'h600);
    readResults(1, 0);
    checkOutput("bnd_loads", 64'(load_cnt - b_load), 64'd10);
    checkOrder("bnd_order", 10, 32'h600);
    checkOutput("bnd_rd_count", 64'(rd_cnt - b_rd), 64'd1);
    checkOutput("bnd_start_once", 64'(start_cnt - b_start), 64'd1);
    checkOutput("bnd_no_err", 64'(err_cnt - b_err), 64'd0);
    checkOutput("bnd_done_pulse", 64'(donep_cnt - b_donep), 64'd1);
    checkOutput("bnd_idle_after", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
